// File: rtl/uart_fifo_tx.sv
// rtl/uart_fifo_tx.sv - FIFO-draining 8N1 UART transmitter.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_fifo_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              emp,
    input  logic [DATA_W-1:0] dataout,
    output logic              rd,
    output logic              txd,
    output logic              busy,
    output logic              tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              bit_end;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        rd      = 1'b0;
        txd     = 1'b1;
        busy    = 1'b1;
        tx_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy   = 1'b0;
                baud_d = '0;
                bit_d  = '0;
                // rst gating keeps the FIFO untouched while reset is held
                if (rst && tx_en && !emp) begin
                    rd      = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                shift_d = dataout;
`ifdef UART_TX_PARITY_EN
                parity_d = ^dataout;
`endif
                baud_d  = '0;
                bit_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                txd = 1'b0;
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                txd = shift_q[0];
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                txd = parity_q;
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    tx_done = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb/tb_uart_fifo_tx.sv - self-checking bench for uart_fifo_tx.
module tb_uart_fifo_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = 2 + NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en;
    logic       emp;
    logic [7:0] dataout = 8'h00;
    logic       rd;
    logic       txd;
    logic       busy;
    logic       tx_done;

    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr = 8'h00;
    logic [7:0] rd_ptr = 8'h00;
    logic       hold_emp = 1'b0;

    int checks = 0;
    int errors = 0;

    uart_fifo_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_en   (tx_en),
        .emp     (emp),
        .dataout (dataout),
        .rd      (rd),
        .txd     (txd),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    assign emp = hold_emp | (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rd) begin
            dataout <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 8'd1;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
        #1;
    endtask

    // Line level k clocks after the rd cycle, from the frame layout
    function automatic logic exp_txd(input logic [7:0] b, input int k);
        int bi;
        if (k < 2) return 1'b1;
        bi = (k - 2) / CPB;
        if (bi == 0) return 1'b0;
        if (bi <= 8) return b[bi-1];
`ifdef UART_TX_PARITY_EN
        if (bi == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic check_frame(input logic [7:0] b, input string name);
        logic [7:0] dec;
        int         idx;
        dec = 8'h00;
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) step();
            checks++;
            if (txd !== exp_txd(b, k) || rd !== (k == 0) || busy !== (k != 0) ||
                tx_done !== (k == FRAME - 1)) begin
                errors++;
                $display("FAIL %s k=%0d got txd=%b rd=%b busy=%b done=%b want txd=%b rd=%b busy=%b done=%b",
                         name, k, txd, rd, busy, tx_done, exp_txd(b, k), (k == 0), (k != 0),
                         (k == FRAME - 1));
            end
            if (k >= 2 + CPB && k < 2 + 9 * CPB && (k - 2) % CPB == CPB / 2) begin
                idx = (k - 2) / CPB - 1;
                dec[idx] = txd;
            end
        end
        checks++;
        if (dec !== b) begin
            errors++;
            $display("FAIL %s_decode got %h want %h", name, dec, b);
        end
    endtask

    task automatic wait_rd(input int budget, input string name, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rd === 1'b1) begin
                got = 1'b1;
                return;
            end
            step();
        end
        checks++;
        errors++;
        $display("FAIL %s_rd_timeout got rd=%b want 1 within %0d clks", name, rd, budget);
    endtask

    task automatic test_reset();
        push(8'h44);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (txd !== 1'b1 || rd !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b0) begin
                errors++;
                $display("FAIL reset cyc=%0d got txd=%b rd=%b busy=%b done=%b want 1 0 0 0",
                         i, txd, rd, busy, tx_done);
            end
        end
        rst = 1'b1;
        #1;
    endtask

    task automatic test_single();
        bit got;
        wait_rd(5, "single", got);
        if (got) check_frame(8'h44, "single");
    endtask

    task automatic test_back_to_back();
        push(8'h55);
        push(8'h22);
        step();
        checks++;
        if (rd !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_rd got %b want 1", rd);
        end
        check_frame(8'h55, "b2b_a");
        step();
        checks++;
        if (rd !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_rd got %b want 1", rd);
        end
        check_frame(8'h22, "b2b_b");
        step();
        checks++;
        if (rd !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drained got rd=%b busy=%b want 0 0", rd, busy);
        end
    endtask

    task automatic test_empty_pause();
        int bad;
        hold_emp = 1'b1;
        push(8'h3C);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (rd !== 1'b0 || txd !== 1'b1) bad++;
        end
        tx_en = 1'b0;
        hold_emp = 1'b0;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (rd !== 1'b0 || txd !== 1'b1) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL pause_idle got %0d bad cycles want 0", bad);
        end
        tx_en = 1'b1;
        #1;
        checks++;
        if (rd !== 1'b1) begin
            errors++;
            $display("FAIL pause_resume_rd got %b want 1", rd);
        end else begin
            check_frame(8'h3C, "pause_frame");
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        int bad;
        step();
        push(8'hA5);
        wait_rd(5, "midrst", got);
        if (!got) return;
        for (int k = 1; k <= 19; k++) step();
        rst = 1'b0;
        step();
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || rd !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort got txd=%b busy=%b rd=%b want 1 0 0", txd, busy, rd);
        end
        step();
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (rd !== 1'b0 || tx_done !== 1'b0 || txd !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midrst_quiet got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        bit         got;
        int         n;
        for (int g = 0; g < 3; g++) begin
            n = $urandom_range(1, 3);
            q.delete();
            for (int i = 0; i < n; i++) begin
                q.push_back(8'($urandom));
                push(q[i]);
            end
            wait_rd(5, "rand", got);
            if (!got) return;
            for (int i = 0; i < n; i++) begin
                if (i > 0) begin
                    step();
                    checks++;
                    if (rd !== 1'b1) begin
                        errors++;
                        $display("FAIL rand_b2b_rd got %b want 1", rd);
                    end
                end
                check_frame(q[i], "rand");
            end
            for (int i = 0; i < $urandom_range(1, 5); i++) step();
            checks++;
            if (rd !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_drained got rd=%b busy=%b want 0 0", rd, busy);
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        bit got;
        push(8'h07);
        wait_rd(5, "par07", got);
        if (got) check_frame(8'h07, "par07");
        step();
        push(8'h44);
        wait_rd(5, "par44", got);
        if (got) check_frame(8'h44, "par44");
    endtask
`endif

    initial begin
        rst   = 1'b0;
        tx_en = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_empty_pause();
        test_reset_mid();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
